// File: rtl/istate_pkg.sv
// istate_pkg: shared FSM encoding and default state-vector field offsets for the inductive-state tracker
package istate_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, VIOLATED} istate_fsm_e;
  localparam int MEM_EN_BIT    = 0;
  localparam int INST_LSB      = 1;
  localparam int INTR_EDGE_BIT = 33;
  localparam int DMISS_BIT     = 34;
endpackage

// File: rtl/istate_pair_cmp.sv
// istate_pair_cmp: masked equality check of one copy pair; lowest-diff encoder only with INDUCTIVE_STATE_FIRST_DIFF_EN
module istate_pair_cmp
  import istate_pkg::*;
#(
  parameter int STATE_W = 35,
  parameter int IW      = $clog2(STATE_W)
) (
  input  logic               en,
  input  logic [STATE_W-1:0] a,
  input  logic [STATE_W-1:0] b,
  output logic               mis
`ifdef INDUCTIVE_STATE_FIRST_DIFF_EN
  ,
  output logic [IW-1:0]      diff_idx
`endif
);
  logic [STATE_W-1:0] d;
  assign d   = a ^ b;
  assign mis = en & (|d);
`ifdef INDUCTIVE_STATE_FIRST_DIFF_EN
  // scanning high to low leaves the lowest set bit as the final winner
  always_comb begin
    diff_idx = '0;
    for (int i = STATE_W - 1; i >= 0; i--)
      if (d[i]) diff_idx = IW'(i);
  end
`endif
endmodule

// File: rtl/inductive_state_tracker.sv
// inductive_state_tracker: captures product-copy state, keeps a history ring, flags relational mismatches
// Optional lowest-differing-bit report enabled by INDUCTIVE_STATE_FIRST_DIFF_EN.
module inductive_state_tracker
  import istate_pkg::*;
#(
  parameter int STATE_W    = 35,
  parameter int NUM_COPIES = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cap_valid,
  output logic                          cap_ready,
  input  logic [NUM_COPIES*STATE_W-1:0] state_in,
  input  logic [NUM_COPIES/2-1:0]       pair_mask,
  input  logic                          clear,
  output logic [NUM_COPIES*STATE_W-1:0] snap_out,
  input  logic [$clog2(DEPTH)-1:0]      rd_idx,
  output logic [NUM_COPIES*STATE_W-1:0] rd_data,
  output logic [CNT_W-1:0]              cap_count,
  output logic                          violation,
  output logic [NUM_COPIES/2-1:0]       viol_pair,
  output logic [$clog2(STATE_W)-1:0]    first_diff_idx
);
  localparam int W  = NUM_COPIES * STATE_W;
  localparam int NP = NUM_COPIES / 2;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(STATE_W);
  istate_fsm_e   state, state_nx;
  logic [W-1:0]  hist [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [NP-1:0] mis;
  logic [IW-1:0] fd_sel;
  logic          accept;
`ifdef INDUCTIVE_STATE_FIRST_DIFF_EN
  logic [IW-1:0] diff [NP];
`endif
  for (genvar p = 0; p < NP; p++) begin : g_pair
    istate_pair_cmp #(.STATE_W(STATE_W), .IW(IW)) u_cmp (
      .en       (pair_mask[p]),
      .a        (state_in[2*p*STATE_W +: STATE_W]),
      .b        (state_in[(2*p+1)*STATE_W +: STATE_W]),
      .mis      (mis[p])
`ifdef INDUCTIVE_STATE_FIRST_DIFF_EN
      ,
      .diff_idx (diff[p])
`endif
    );
  end
`ifdef INDUCTIVE_STATE_FIRST_DIFF_EN
  // lowest-numbered violating pair decides the reported bit
  always_comb begin
    fd_sel = '0;
    for (int p = NP - 1; p >= 0; p--)
      if (mis[p]) fd_sel = diff[p];
  end
`else
  assign fd_sel = '0;
`endif
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = clear ? IDLE : accept ? ((|mis) ? VIOLATED : TRACK) : state;
  always_comb begin
    cap_ready = (state != VIOLATED) && !clear;
    violation = (state == VIOLATED);
  end
  assign accept  = cap_valid & cap_ready;
  assign rd_data = hist[wr_ptr - AW'(1) - rd_idx];
  always_ff @(posedge clock)
    if (reset) begin
      snap_out       <= '0;
      wr_ptr         <= '0;
      cap_count      <= '0;
      viol_pair      <= '0;
      first_diff_idx <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (clear) begin
      viol_pair      <= '0;
      first_diff_idx <= '0;
    end else if (accept) begin
      snap_out     <= state_in;
      hist[wr_ptr] <= state_in;
      wr_ptr       <= wr_ptr + AW'(1);
      if (~&cap_count) cap_count <= cap_count + CNT_W'(1);
      if (|mis) begin
        viol_pair      <= mis;
        first_diff_idx <= fd_sel;
      end
    end
endmodule

// File: tb/tb_inductive_state_tracker.sv
// tb_inductive_state_tracker: directed checks of capture, history wrap, violation, clear, saturation and reset
module tb_inductive_state_tracker;
  localparam int SW = 35;
  localparam int NC = 4;
  localparam int W  = SW * NC;
  logic          clock = 0;
  logic          reset, cap_valid, clear;
  logic [W-1:0]  state_in;
  logic [1:0]    pair_mask, rd_idx;
  logic          cap_ready, violation, cap_ready2, violation2;
  logic [W-1:0]  snap_out, rd_data, snap_out2, rd_data2;
  logic [15:0]   cap_count;
  logic [1:0]    cap_count2, viol_pair, viol_pair2;
  logic [5:0]    first_diff_idx, first_diff_idx2;
  int            errors = 0;
  int            checks = 0;
  logic [5:0]    fd_exp;
  always #5 clock = ~clock;
  inductive_state_tracker dut (
    .clock(clock), .reset(reset), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .state_in(state_in), .pair_mask(pair_mask), .clear(clear), .snap_out(snap_out),
    .rd_idx(rd_idx), .rd_data(rd_data), .cap_count(cap_count), .violation(violation),
    .viol_pair(viol_pair), .first_diff_idx(first_diff_idx)
  );
  inductive_state_tracker #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .cap_valid(cap_valid), .cap_ready(cap_ready2),
    .state_in(state_in), .pair_mask(pair_mask), .clear(clear), .snap_out(snap_out2),
    .rd_idx(rd_idx), .rd_data(rd_data2), .cap_count(cap_count2), .violation(violation2),
    .viol_pair(viol_pair2), .first_diff_idx(first_diff_idx2)
  );
  function automatic logic [SW-1:0] v(int k);
    logic [SW-1:0] base;
    base = 35'h1_2345_6789;
    return base + SW'(k);
  endfunction
  function automatic logic [W-1:0] all4(int k);
    return {4{v(k)}};
  endfunction
  function automatic logic [W-1:0] flip3(int k);
    logic [SW-1:0] f;
    f = v(k) ^ SW'(128);
    return {f, v(k), v(k), v(k)};
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
`ifdef INDUCTIVE_STATE_FIRST_DIFF_EN
    fd_exp = 6'd7;
`else
    fd_exp = 6'd0;
`endif
    reset = 1; cap_valid = 0; clear = 0; state_in = '0; pair_mask = 2'b11; rd_idx = 0;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_rd_data", rd_data, '0);
    chk("rst_cap_ready", W'(cap_ready), W'(1));
    chk("rst_cap_count", W'(cap_count), W'(0));
    chk("rst_violation", W'(violation), W'(0));
    chk("rst_snap", snap_out, '0);
    for (int k = 1; k <= 5; k++) begin
      cap_valid = 1; state_in = all4(k);
      tick();
    end
    cap_valid = 0;
    #1;
    chk("cnt5", W'(cap_count), W'(5));
    chk("snap5", snap_out, all4(5));
    rd_idx = 0; #1;
    chk("hist_age0", rd_data, all4(5));
    rd_idx = 3; #1;
    chk("hist_age3_wrap", rd_data, all4(2));
    chk("no_violation", W'(violation), W'(0));
    chk("sat_cnt_w2", W'(cap_count2), W'(3));
    cap_valid = 1; state_in = flip3(6); pair_mask = 2'b01;
    tick();
    cap_valid = 0; #1;
    chk("masked_no_viol", W'(violation), W'(0));
    chk("masked_ready", W'(cap_ready), W'(1));
    chk("cnt6", W'(cap_count), W'(6));
    cap_valid = 1; state_in = flip3(7); pair_mask = 2'b10;
    tick();
    cap_valid = 0; #1;
    chk("viol_set", W'(violation), W'(1));
    chk("viol_pair", W'(viol_pair), W'(2'b10));
    chk("viol_ready0", W'(cap_ready), W'(0));
    chk("first_diff", W'(first_diff_idx), W'(fd_exp));
    chk("viol_snap", snap_out, flip3(7));
    chk("cnt7", W'(cap_count), W'(7));
    cap_valid = 1; state_in = all4(9);
    tick();
    chk("viol_blocks_cap", W'(cap_count), W'(7));
    chk("viol_hold", W'(violation), W'(1));
    clear = 1; #1;
    chk("clear_ready0", W'(cap_ready), W'(0));
    tick();
    clear = 0; cap_valid = 0; #1;
    chk("clear_viol", W'(violation), W'(0));
    chk("clear_vpair", W'(viol_pair), W'(0));
    chk("clear_cnt", W'(cap_count), W'(7));
    chk("clear_snap", snap_out, flip3(7));
    chk("clear_ready1", W'(cap_ready), W'(1));
    pair_mask = 2'b11; cap_valid = 1; state_in = all4(8);
    tick();
    cap_valid = 0; rd_idx = 1; #1;
    chk("after_clear_cnt", W'(cap_count), W'(8));
    chk("after_clear_age1", rd_data, flip3(7));
    chk("after_clear_noviol", W'(violation), W'(0));
    cap_valid = 1; reset = 1; state_in = all4(10);
    tick();
    reset = 0; cap_valid = 0; rd_idx = 0; #1;
    chk("mid_rst_cnt", W'(cap_count), W'(0));
    chk("mid_rst_snap", snap_out, '0);
    chk("mid_rst_hist", rd_data, '0);
    chk("mid_rst_cnt2", W'(cap_count2), W'(0));
    chk("mid_rst_viol2", W'(violation2), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
